// File: rtl/ft_gate_ctrl_pkg.sv
// Common types and the state-to-output decode for the gate controller.
`include "ft_defs.vh"

package ft_gate_ctrl_pkg;

  localparam int ST_W = 2;

  // Strobes driven by the controller; all come straight from state.
  typedef struct packed {
    logic cnt_en;
    logic rst_cnt;
    logic load;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Pure Moore decode: one-hot strobes per state, so CNT_EN/RST_CNT/LOAD
  // can never overlap.
  function automatic ctrl_out_t decode_state(input logic [ST_W-1:0] st);
    ctrl_out_t o;
    o = '0;
    case (st)
      `FT_ST_CLR:   o.rst_cnt = 1'b1;
      `FT_ST_GATE:  o.cnt_en  = 1'b1;
      `FT_ST_LATCH: begin
        o.load = 1'b1;
        o.done = 1'b1;
      end
      default: ;
    endcase
    o.busy = (st != `FT_ST_IDLE);
    return o;
  endfunction

endpackage

// File: rtl/ft_defs.vh
// Shared 2-bit state encodings for the gate controller and its bench.
`ifndef FT_DEFS_VH
`define FT_DEFS_VH
`define FT_ST_IDLE  2'b00
`define FT_ST_CLR   2'b01
`define FT_ST_GATE  2'b10
`define FT_ST_LATCH 2'b11
`endif

// File: rtl/ft_gate_cnt.sv
// Gate-window down-counter: load, decrement to zero, zero flag.
module ft_gate_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ft_gate_ctrl.sv
// Frequency-counter gate controller: CLR -> GATE (L cycles) -> LATCH,
// single-shot or auto-repeating, with abort and wrapping sequence count.
`include "ft_defs.vh"

module ft_gate_ctrl
  import ft_gate_ctrl_pkg::*;
#(
  parameter int GATE_W = 16,
  parameter int SEQ_W  = 8
) (
  input  logic              CLKK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              MODE,
  input  logic              ABORT,
  input  logic [GATE_W-1:0] GATE_LEN,
  output logic              CNT_EN,
  output logic              RST_CNT,
  output logic              LOAD,
  output logic              BUSY,
  output logic              DONE,
  output logic [SEQ_W-1:0]  SEQ_CNT
);

  localparam logic [1:0] S_IDLE  = `FT_ST_IDLE;
  localparam logic [1:0] S_CLR   = `FT_ST_CLR;
  localparam logic [1:0] S_GATE  = `FT_ST_GATE;
  localparam logic [1:0] S_LATCH = `FT_ST_LATCH;

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;     // 1 = single-shot
  logic [GATE_W-1:0] len_q, len_d;       // captured gate length
  logic [SEQ_W-1:0]  seq_q, seq_d;

  logic              gate_zero;
  logic [GATE_W-1:0] gate_ld_val;
  ctrl_out_t         outs;

  // The counter holds "cycles remaining after this one", so a window of L
  // cycles loads L-1 and leaves GATE on the zero flag. Length 0 acts as 1.
  assign gate_ld_val = (len_q == '0) ? '0 : len_q - GATE_W'(1);

  ft_gate_cnt #(.W(GATE_W)) u_gate_cnt (
    .clk_i      (CLKK),
    .rst_ni     (RST_N),
    .load_i     (state_q == S_CLR),
    .load_val_i (gate_ld_val),
    .dec_i      (state_q == S_GATE),
    .zero_o     (gate_zero)
  );

  // Next-state logic; ABORT beats every other transition. Settings are only
  // captured at a window start so mid-window input changes are ignored.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    seq_d   = seq_q;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d = S_CLR;
          mode_d  = MODE;
          len_d   = GATE_LEN;
        end
      end
      S_CLR:   state_d = ABORT ? S_IDLE : S_GATE;
      S_GATE: begin
        if (ABORT)          state_d = S_IDLE;
        else if (gate_zero) state_d = S_LATCH;
      end
      S_LATCH: begin
        // LOAD already went out this cycle, so the measurement counts even
        // if ABORT cancels the restart.
        seq_d = seq_q + SEQ_W'(1);
        if (ABORT || mode_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLR;
          len_d   = GATE_LEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers, asynchronously reset to an idle single-shot.
  always_ff @(posedge CLKK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b1;
      len_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
    end
  end

  assign outs    = decode_state(state_q);
  assign CNT_EN  = outs.cnt_en;
  assign RST_CNT = outs.rst_cnt;
  assign LOAD    = outs.load;
  assign BUSY    = outs.busy;
  assign DONE    = outs.done;
  assign SEQ_CNT = seq_q;

endmodule

// File: tb/tb_ft_gate_ctrl.sv
// Directed bench for ft_gate_ctrl: per-cycle vector table plus hand-written
// sequences for long gates, async reset and sequence-count wrap.
`include "ft_defs.vh"

module tb_ft_gate_ctrl;

  localparam int GW = 8;
  localparam int SW = 2;

  localparam logic [1:0] I = `FT_ST_IDLE;
  localparam logic [1:0] C = `FT_ST_CLR;
  localparam logic [1:0] G = `FT_ST_GATE;
  localparam logic [1:0] L = `FT_ST_LATCH;

  logic          CLKK = 1'b0;
  logic          RST_N, START, MODE, ABORT;
  logic [GW-1:0] GATE_LEN;
  logic          CNT_EN, RST_CNT, LOAD, BUSY, DONE;
  logic [SW-1:0] SEQ_CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          st, md, ab;
    logic [GW-1:0] ln;
    logic [1:0]    ph;   // phase expected in this cycle
    logic [SW-1:0] sq;   // SEQ_CNT expected in this cycle
  } vec_t;

  vec_t tbl[$];

  always #5 CLKK = ~CLKK;

  ft_gate_ctrl #(.GATE_W(GW), .SEQ_W(SW)) dut (
    .CLKK(CLKK), .RST_N(RST_N), .START(START), .MODE(MODE), .ABORT(ABORT),
    .GATE_LEN(GATE_LEN), .CNT_EN(CNT_EN), .RST_CNT(RST_CNT), .LOAD(LOAD),
    .BUSY(BUSY), .DONE(DONE), .SEQ_CNT(SEQ_CNT)
  );

  // Expected {CNT_EN,RST_CNT,LOAD,BUSY,DONE} per phase.
  function automatic logic [4:0] ph_flags(input logic [1:0] ph);
    case (ph)
      `FT_ST_CLR:   return 5'b01010;
      `FT_ST_GATE:  return 5'b10010;
      `FT_ST_LATCH: return 5'b00111;
      default:      return 5'b00000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_phase(input string nm, input logic [1:0] ph, input logic [SW-1:0] sq);
    check({nm, " outs"}, {27'd0, CNT_EN, RST_CNT, LOAD, BUSY, DONE}, {27'd0, ph_flags(ph)});
    check({nm, " seq"}, {30'd0, SEQ_CNT}, {30'd0, sq});
    check({nm, " excl"}, {31'd0, (CNT_EN & RST_CNT) | (CNT_EN & LOAD) | (RST_CNT & LOAD)}, 32'd0);
  endtask

  task automatic drive(input logic st, input logic md, input logic ab, input logic [GW-1:0] ln);
    START = st; MODE = md; ABORT = ab; GATE_LEN = ln;
  endtask

  task automatic add(input logic st, input logic md, input logic ab, input logic [GW-1:0] ln,
                     input logic [1:0] ph, input logic [SW-1:0] sq);
    vec_t v;
    v.st = st; v.md = md; v.ab = ab; v.ln = ln; v.ph = ph; v.sq = sq;
    tbl.push_back(v);
  endtask

  initial begin
    int   n;
    logic seen;
    logic [SW-1:0] wexp [5];
    wexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Row r: outputs checked in cycle r, then inputs driven for the next edge.
    // Single-shot L=5; START/MODE/GATE_LEN wiggled mid-window are ignored.
    add(1,1,0,5, I,0);
    add(1,0,0,9, C,0);
    repeat (5) add(1,0,0,9, G,0);
    add(0,0,0,9, L,0);
    // GATE_LEN=0 acts as a one-cycle window.
    add(1,1,0,0, I,1);
    add(0,1,0,0, C,1);
    add(0,1,0,7, G,1);
    add(0,1,0,7, L,1);
    // Abort in the third of five gate cycles, then ABORT+START in IDLE.
    add(1,1,0,5, I,2);
    add(0,1,0,5, C,2);
    add(0,1,0,5, G,2);
    add(0,1,0,5, G,2);
    add(0,1,1,5, G,2);
    add(1,1,1,5, I,2);
    // Continuous L=3, length changed to 2 mid-window, restart uses 2;
    // abort in LATCH still counts (3 wraps to 0) but stops the restart.
    add(1,0,0,3, I,2);
    add(0,0,0,3, C,2);
    repeat (3) add(0,0,0,2, G,2);
    add(0,0,0,2, L,2);
    add(1,0,0,7, C,3);
    add(0,0,0,7, G,3);
    add(0,0,0,7, G,3);
    add(0,0,1,7, L,3);
    add(0,1,0,0, I,0);
    add(0,1,0,0, I,0);

    drive(0,0,0,0);
    RST_N = 1'b0;
    repeat (2) @(negedge CLKK);
    chk_phase("reset", I, 0);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      @(negedge CLKK);
      chk_phase($sformatf("vec%0d", i), tbl[i].ph, tbl[i].sq);
      drive(tbl[i].st, tbl[i].md, tbl[i].ab, tbl[i].ln);
    end

    // Longest window: 255 CNT_EN cycles.
    @(negedge CLKK);
    drive(1,1,0,8'd255);
    n = 0; seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge CLKK);
      drive(0,1,0,8'd255);
      if (CNT_EN) n++;
      if (LOAD) seen = 1'b1;
    end
    check("len255 load seen", {31'd0, seen}, 32'd1);
    check("len255 cnt_en cycles", n, 32'd255);
    @(negedge CLKK);
    chk_phase("len255 end", I, 1);

    // Async reset in the middle of a gate window.
    drive(1,1,0,8'd10);
    @(negedge CLKK);
    drive(0,1,0,8'd10);
    repeat (3) @(negedge CLKK);
    check("pre-rst cnt_en", {31'd0, CNT_EN}, 32'd1);
    #2 RST_N = 1'b0;
    #1 chk_phase("async rst", I, 0);
    @(negedge CLKK);
    RST_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLKK);
      chk_phase($sformatf("post-rst%0d", c), I, 0);
    end

    // Continuous L=1: sequence count 1,2,3,0,1.
    drive(1,0,0,8'd1);
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge CLKK);
        drive(0,0,0,8'd1);
        if (LOAD) seen = 1'b1;
      end
      check($sformatf("wrap%0d load seen", k), {31'd0, seen}, 32'd1);
      @(negedge CLKK);
      check($sformatf("wrap%0d seq", k), {30'd0, SEQ_CNT}, {30'd0, wexp[k]});
    end
    drive(0,0,1,8'd1);
    @(negedge CLKK);
    drive(0,0,0,8'd1);
    chk_phase("wrap abort", I, 1);
    @(negedge CLKK);
    chk_phase("wrap idle", I, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
